// File: rtl/conv3x3_row_engine.sv
// 3x3 valid convolution over an 8x8 image streamed from an async-read pixel ROM.
// Optional build macro CONV_DEBUG_STATE_EN adds a current_state debug output.
module conv3x3_row_engine #(
  parameter logic [287:0] KERNEL = {9{32'h00000001}},
  parameter int           IMG_W  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic [31:0]    pixel_in,
  output logic [5:0]     rom_addr,
  output logic [191:0]   o_pixel_bus,
  output logic           o_valid,
  output logic           o_done
`ifdef CONV_DEBUG_STATE_EN
  ,
  output logic [2:0]     current_state
`endif
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] CALC  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;

  localparam int OUT_W = IMG_W - 2;

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic        row_end;
  logic        calc_fire;

  logic [31:0] in_row   [IMG_W];
  logic [31:0] full_row [IMG_W];
  logic [31:0] row0     [IMG_W];
  logic [31:0] row1     [IMG_W];
  logic [31:0] row2     [IMG_W];
  logic [31:0] conv_out [OUT_W];

  assign row_end   = (state == FETCH) && (rom_addr[2:0] == 3'd7);
  assign calc_fire = (state == CALC) && enable;

  // Dropping enable in any active state aborts straight back to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (enable) next_state = FETCH;
      FETCH: begin
        if (!enable)
          next_state = IDLE;
        else if (row_end && (rom_addr[5:3] >= 3'd2))
          next_state = CALC;
      end
      CALC: begin
        if (!enable)
          next_state = IDLE;
        else if (rom_addr == 6'd63)
          next_state = DONE;
        else
          next_state = FETCH;
      end
      DONE:  if (!enable) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  // The last pixel of the frame leaves the address parked at 63 rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rom_addr <= 6'd0;
    else if (next_state == IDLE)
      rom_addr <= 6'd0;
    else if ((state == FETCH) && (rom_addr != 6'd63))
      rom_addr <= rom_addr + 6'd1;
  end

  always_comb begin
    for (int i = 0; i < IMG_W; i++)
      full_row[i] = (i == IMG_W - 1) ? pixel_in : in_row[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IMG_W; i++) begin
        in_row[i] <= '0;
        row0[i]   <= '0;
        row1[i]   <= '0;
        row2[i]   <= '0;
      end
    end else if ((state == FETCH) && enable) begin
      in_row[rom_addr[2:0]] <= pixel_in;
      if (row_end) begin
        for (int i = 0; i < IMG_W; i++) begin
          row0[i] <= row1[i];
          row1[i] <= row2[i];
          row2[i] <= full_row[i];
        end
      end
    end
  end

  // Low 32 bits of a product are the same signed or unsigned, so plain wrap arithmetic suffices.
  always_comb begin
    for (int c = 0; c < OUT_W; c++) begin
      conv_out[c] = '0;
      for (int k = 0; k < 3; k++) begin
        conv_out[c] = conv_out[c]
                    + KERNEL[287 - 32*k -: 32]       * row0[c+k]
                    + KERNEL[287 - 32*(3+k) -: 32]   * row1[c+k]
                    + KERNEL[287 - 32*(6+k) -: 32]   * row2[c+k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_pixel_bus <= '0;
      o_valid     <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_valid <= calc_fire;
      o_done  <= (next_state == DONE);
      if (calc_fire) begin
        for (int c = 0; c < OUT_W; c++)
          o_pixel_bus[191 - 32*c -: 32] <= conv_out[c];
      end
    end
  end

`ifdef CONV_DEBUG_STATE_EN
  assign current_state = state;
`endif

endmodule

// File: tb/tb_conv3x3_row_engine.sv
// Self-checking bench for conv3x3_row_engine: three kernels run in lockstep against
// an arithmetic reference model and a cycle schedule derived from the frame rules.
module tb_conv3x3_row_engine;

  localparam int ND = 3;
  localparam logic [287:0] K0 = {9{32'h00000001}};
  localparam logic [287:0] K1 = {32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
  localparam logic [287:0] K2 = {32'hFFFFFFFF, 32'd2, 32'hFFFFFFFD, 32'd4, 32'd5,
                                 32'hFFFFFFFA, 32'd7, 32'hFFFFFFF8, 32'd9};

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [31:0]   img       [64];
  logic [31:0]   pixel_in  [ND];
  logic [5:0]    addr      [ND];
  logic [191:0]  bus       [ND];
  logic          valid     [ND];
  logic          done      [ND];
`ifdef CONV_DEBUG_STATE_EN
  logic [2:0]    dbg_state [ND];
`endif

  int compareCount  = 0;
  int mismatchCount = 0;
  logic [191:0] firstBus0;
  logic [191:0] lastBus0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign pixel_in[0] = img[addr[0]];
  assign pixel_in[1] = img[addr[1]];
  assign pixel_in[2] = img[addr[2]];

  conv3x3_row_engine #(.KERNEL(K0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pixel_in(pixel_in[0]),
    .rom_addr(addr[0]), .o_pixel_bus(bus[0]), .o_valid(valid[0]), .o_done(done[0])
`ifdef CONV_DEBUG_STATE_EN
    , .current_state(dbg_state[0])
`endif
  );

  conv3x3_row_engine #(.KERNEL(K1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pixel_in(pixel_in[1]),
    .rom_addr(addr[1]), .o_pixel_bus(bus[1]), .o_valid(valid[1]), .o_done(done[1])
`ifdef CONV_DEBUG_STATE_EN
    , .current_state(dbg_state[1])
`endif
  );

  conv3x3_row_engine #(.KERNEL(K2)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pixel_in(pixel_in[2]),
    .rom_addr(addr[2]), .o_pixel_bus(bus[2]), .o_valid(valid[2]), .o_done(done[2])
`ifdef CONV_DEBUG_STATE_EN
    , .current_state(dbg_state[2])
`endif
  );

  task automatic checkOutput(input string tag, input logic [191:0] observed,
                             input logic [191:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [287:0] kernelOf(input int d);
    if (d == 0) return K0;
    if (d == 1) return K1;
    return K2;
  endfunction

  // Output row k of kernel d, computed directly from the image with 32-bit wrapping ints.
  function automatic logic [191:0] modelRow(input int d, input int k);
    logic [287:0] kern;
    logic [191:0] res;
    int acc;
    int w;
    kern = kernelOf(d);
    res  = '0;
    for (int c = 0; c < 6; c++) begin
      acc = 0;
      for (int r = 0; r < 3; r++)
        for (int kk = 0; kk < 3; kk++) begin
          w   = int'(kern[287 - 32*(3*r + kk) -: 32]);
          acc = acc + w * int'(img[8*(k + r) + c + kk]);
        end
      res[191 - 32*c -: 32] = acc;
    end
    return res;
  endfunction

  task automatic checkAll(input string tag, input logic [5:0] expAddr, input logic expValid,
                          input logic expDone);
    for (int d = 0; d < ND; d++) begin
      checkOutput($sformatf("%s d%0d addr", tag, d), 192'(addr[d]), 192'(expAddr));
      checkOutput($sformatf("%s d%0d valid", tag, d), 192'(valid[d]), 192'(expValid));
      checkOutput($sformatf("%s d%0d done", tag, d), 192'(done[d]), 192'(expDone));
    end
  endtask

  // Runs one whole frame from IDLE and checks every cycle against the expected schedule.
  task automatic applyStimulus(input string tag);
    int schedAddr[$];
    bit schedCalc[$];
    int rowIdx;
    logic [5:0] ea;
    logic ev;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        schedAddr.push_back(8*r + c);
        schedCalc.push_back(1'b0);
      end
      if (r >= 2) begin
        schedAddr.push_back((r == 7) ? 63 : 8*(r + 1));
        schedCalc.push_back(1'b1);
      end
    end
    rowIdx = 0;
    enable = 1'b1;
    @(posedge clk);
    for (int t = 0; t < 72; t++) begin
      @(negedge clk);
      ea = (t < 70) ? 6'(schedAddr[t]) : 6'd63;
      ev = (t >= 1) && (t <= 70) && schedCalc[t-1];
      checkAll($sformatf("%s t%0d", tag, t), ea, ev, t >= 70);
      if (ev) begin
        for (int d = 0; d < ND; d++)
          checkOutput($sformatf("%s row%0d d%0d bus", tag, rowIdx, d), bus[d], modelRow(d, rowIdx));
        if (rowIdx == 0) firstBus0 = bus[0];
        if (rowIdx == 5) lastBus0  = bus[0];
        rowIdx++;
      end
    end
    checkOutput({tag, " rows"}, 192'(rowIdx), 192'(6));
  endtask

  task automatic goIdle(input string tag);
    enable = 1'b0;
    @(negedge clk);
    checkAll({tag, " idle"}, 6'd0, 1'b0, 1'b0);
  endtask

  task automatic fillRamp();
    for (int a = 0; a < 64; a++) img[a] = 32'(a);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [191:0] held;
    bit found;
    rst_n  = 1'b0;
    enable = 1'b0;
    fillRamp();
    repeat (2) @(negedge clk);
    for (int d = 0; d < ND; d++)
      checkOutput($sformatf("reset d%0d bus", d), bus[d], '0);
    checkAll("reset", 6'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp image: spec reference rows for the all-ones kernel.
    applyStimulus("ramp");
    checkOutput("ramp first row", firstBus0, {32'd81, 32'd90, 32'd99, 32'd108, 32'd117, 32'd126});
    checkOutput("ramp last row", lastBus0, {32'd441, 32'd450, 32'd459, 32'd468, 32'd477, 32'd486});
    checkOutput("center last row", bus[1], {32'd49, 32'd50, 32'd51, 32'd52, 32'd53, 32'd54});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkAll($sformatf("done hold %0d", i), 6'd63, 1'b0, 1'b1);
      checkOutput($sformatf("done hold %0d bus", i), bus[0], modelRow(0, 5));
    end
    goIdle("after ramp");

    // Saturating-looking input must wrap, not clamp.
    for (int a = 0; a < 64; a++) img[a] = 32'h7FFFFFFF;
    applyStimulus("maxval");
    checkOutput("maxval wrap", bus[0], {6{32'h7FFFFFF7}});
    goIdle("after maxval");

    // Abort at address 20, idle five cycles, then a full frame.
    fillRamp();
    held   = bus[0];
    enable = 1'b1;
    @(posedge clk);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (addr[0] == 6'd20) found = 1'b1;
    end
    checkOutput("abort reach addr20", 192'(found), 192'(1));
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkAll($sformatf("abort idle %0d", i), 6'd0, 1'b0, 1'b0);
      checkOutput($sformatf("abort hold bus %0d", i), bus[0], held);
    end
    applyStimulus("restart");
    checkOutput("restart first row", firstBus0, {32'd81, 32'd90, 32'd99, 32'd108, 32'd117, 32'd126});
    goIdle("after restart");

    for (int f = 0; f < 2; f++) begin
      for (int a = 0; a < 64; a++) img[a] = $urandom;
      applyStimulus($sformatf("rand%0d", f));
      goIdle($sformatf("after rand%0d", f));
    end

    // Asynchronous reset in the first CALC cycle (cycle 24 of the frame).
    fillRamp();
    enable = 1'b1;
    @(posedge clk);
    for (int t = 0; t < 25; t++) @(negedge clk);
    checkOutput("pre-reset addr", 192'(addr[0]), 192'(24));
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++)
      checkOutput($sformatf("async reset d%0d bus", d), bus[d], '0);
    checkAll("async reset", 6'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("post-reset");
    goIdle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
